ula_adder_bios: RTL and testbench
=================================

// Module: ula_adder_bios
// PURPOSE
//  Lapido execution/boot helper that bundles three datapath pieces:
//  - the EX-stage ALU (ULA), combinational;
//  - the IF-stage PC incrementer (adder);
//  - the BIOS boot streamer, which copies a fixed program into instruction
//    memory after reset, one word per clock, before the PC is released.
//  Sits between the id_ex/ex_mem pipeline registers (ALU), the program
//  counter (adder) and the memory write port (bios).
// PARAMETERS
//  BIOS_WORDS  6   number of program words streamed after reset (1..16)
// PORTS
//  clock         in   1   single system clock; bios logic uses rising edge
//  reset         in   1   asynchronous, active-low reset
//  A             in   32  ALU operand A
//  B             in   32  ALU operand B (register or sign-extended immediate)
//  opcode        in   5   ALU operation select
//  Out           out  32  ALU result
//  zero          out  1   1 when Out == 0
//  pc_in         in   32  current PC
//  pc_plus1      out  32  pc_in + 1
//  captured_data out  32  BIOS word currently presented to memory
//  bios_addr     out  32  memory address for captured_data
//  bios_we       out  1   write strobe for captured_data/bios_addr
//  bios_done     out  1   sticky; 1 once all BIOS_WORDS are written
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  ALU (purely combinational; independent of clock/reset):
//  - All ops are 32-bit and wrap modulo 2^32. There are no carry or overflow outputs.
//  - Ops: 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR; 4 XOR; 5 NOT A; 6 NAND; 7 NOR;
//    8 SLL A<<B[4:0]; 9 SRL A>>B[4:0]; 10 SRA arithmetic A>>>B[4:0];
//    11 SLT signed (A<B)?1:0; 12 SLTU unsigned; 13 PASS B; 14 INC A+1;
//    15 DEC A-1; 16 LUI B<<16.
//  - Opcodes 17..31 give Out = 0, and therefore zero = 1.
//  - zero = (Out == 32'h0) for every opcode.
//  Adder: pc_plus1 = pc_in + 1, combinational; 32'hFFFFFFFF wraps to 0.
//  BIOS streamer (rising edge of clock):
//  - Internal index idx runs 0..BIOS_WORDS.
//  - reset low (asynchronous): idx = 0, captured_data = 0, bios_addr = 0,
//    bios_we = 0, bios_done = 0.
//  - Each rising edge with reset high and idx < BIOS_WORDS:
//    captured_data <= ROM[idx], bios_addr <= idx, bios_we <= 1, idx <= idx+1.
//  - First edge with idx == BIOS_WORDS: bios_we <= 0, captured_data <= 0,
//    bios_done <= 1. This state holds until the next reset.
//  - The word for address k is therefore valid with bios_we = 1 during the
//    cycle after edge k+1. Memory samples it on the falling edge.
//  - Reset asserted mid-stream aborts the copy. On release the copy restarts
//    from word 0.
//  - ROM contents (words 0..5): 01100005, 01200003, 02312000, 03412000,
//    0F000000, 00000000 (hex). Words >= 6 read 0.
// TESTING
//  - ALU: A=5, B=3: op0 -> 8 with zero=0; op1 -> 2; op1 with A=B=7 -> 0 with
//    zero=1; op11 with A=FFFFFFFF, B=1 -> 1; op12 with the same A, B -> 0.
//  - Shifts/LUI: A=80000000, B=4: op9 -> 08000000; op10 -> F8000000;
//    op8 with A=1, B=31 -> 80000000; op16 with B=1234 -> 12340000.
//  - Illegal op: opcode 20 with A=5, B=3 -> Out=0, zero=1.
//  - Adder: pc_in=0 -> 1; pc_in=FFFFFFFF -> 0.
//  - BIOS stream: release reset, then run 6 edges. bios_addr must be
//    0,1,2,3,4,5 with captured_data 01100005..00000000 and bios_we=1.
//    7th edge -> bios_we=0, bios_done=1.
//  - Reset mid-stream: assert reset after word 2 -> all bios outputs 0
//    immediately. On release, the next edge presents addr 0 / 01100005.

Source files
------------

// File: rtl/ula_adder_bios.sv
// EX-stage ALU and IF-stage PC incrementer (both combinational), plus a BIOS streamer that copies the
// boot program into instruction memory after reset: one word per clock, no backpressure, then bios_done stays set.
module ula_adder_bios #(
   parameter int BIOS_WORDS = 6
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [4:0]  opcode,
   output logic [31:0] Out,
   output logic        zero,
   input  logic [31:0] pc_in,
   output logic [31:0] pc_plus1,
   output logic [31:0] captured_data,
   output logic [31:0] bios_addr,
   output logic        bios_we,
   output logic        bios_done
);

   localparam logic [4:0] LAST_IDX = 5'(BIOS_WORDS);

   typedef enum logic [4:0] {
      OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3,
      OP_XOR  = 5'd4,  OP_NOT  = 5'd5,  OP_NAND = 5'd6,  OP_NOR  = 5'd7,
      OP_SLL  = 5'd8,  OP_SRL  = 5'd9,  OP_SRA  = 5'd10, OP_SLT  = 5'd11,
      OP_SLTU = 5'd12, OP_PASS = 5'd13, OP_INC  = 5'd14, OP_DEC  = 5'd15,
      OP_LUI  = 5'd16
   } alu_op_e;

   logic [31:0] alu_out;
   logic [4:0]  shamt;

   assign shamt = B[4:0];

   always_comb begin
      alu_out = 32'h0;
      case (alu_op_e'(opcode))
         OP_ADD:  alu_out = A + B;
         OP_SUB:  alu_out = A - B;
         OP_AND:  alu_out = A & B;
         OP_OR:   alu_out = A | B;
         OP_XOR:  alu_out = A ^ B;
         OP_NOT:  alu_out = ~A;
         OP_NAND: alu_out = ~(A & B);
         OP_NOR:  alu_out = ~(A | B);
         OP_SLL:  alu_out = A << shamt;
         OP_SRL:  alu_out = A >> shamt;
         OP_SRA:  alu_out = $signed(A) >>> shamt;
         OP_SLT:  alu_out = {31'b0, $signed(A) < $signed(B)};
         OP_SLTU: alu_out = {31'b0, A < B};
         OP_PASS: alu_out = B;
         OP_INC:  alu_out = A + 32'd1;
         OP_DEC:  alu_out = A - 32'd1;
         OP_LUI:  alu_out = {B[15:0], 16'h0};
         default: alu_out = 32'h0;
      endcase
   end

   assign Out      = alu_out;
   assign zero     = (alu_out == 32'h0);
   assign pc_plus1 = pc_in + 32'd1;

   function automatic logic [31:0] rom_word(input logic [4:0] i);
      case (i)
         5'd0:    rom_word = 32'h0110_0005;
         5'd1:    rom_word = 32'h0120_0003;
         5'd2:    rom_word = 32'h0231_2000;
         5'd3:    rom_word = 32'h0341_2000;
         5'd4:    rom_word = 32'h0F00_0000;
         default: rom_word = 32'h0000_0000;
      endcase
   endfunction

   logic [4:0]  idx_q,  idx_d;
   logic [31:0] data_q, data_d;
   logic [31:0] addr_q, addr_d;
   logic        we_q,   we_d;
   logic        done_q, done_d;

   always_comb begin
      idx_d  = idx_q;
      data_d = data_q;
      addr_d = addr_q;
      we_d   = we_q;
      done_d = done_q;
      if (idx_q < LAST_IDX) begin
         data_d = rom_word(idx_q);
         addr_d = {27'b0, idx_q};
         we_d   = 1'b1;
         idx_d  = idx_q + 5'd1;
      end else begin
         // Terminal state: idx parks at LAST_IDX so the copy never repeats.
         data_d = 32'h0;
         we_d   = 1'b0;
         done_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         idx_q  <= 5'd0;
         data_q <= 32'h0;
         addr_q <= 32'h0;
         we_q   <= 1'b0;
         done_q <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         data_q <= data_d;
         addr_q <= addr_d;
         we_q   <= we_d;
         done_q <= done_d;
      end
   end

   assign captured_data = data_q;
   assign bios_addr     = addr_q;
   assign bios_we       = we_q;
   assign bios_done     = done_q;

endmodule

// File: tb/tb_ula_adder_bios.sv
// Directed bench for ula_adder_bios: ALU ops, PC incrementer, BIOS stream and mid-stream reset.
module tb_ula_adder_bios;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] A, B;
   logic [4:0]  opcode;
   logic [31:0] Out;
   logic        zero;
   logic [31:0] pc_in;
   logic [31:0] pc_plus1;
   logic [31:0] captured_data;
   logic [31:0] bios_addr;
   logic        bios_we;
   logic        bios_done;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] rom_exp [6] = '{32'h0110_0005, 32'h0120_0003, 32'h0231_2000,
                                32'h0341_2000, 32'h0F00_0000, 32'h0000_0000};

   always #5 clock = ~clock;

   ula_adder_bios #(.BIOS_WORDS(6)) dut (
      .clock         (clock),
      .reset         (reset),
      .A             (A),
      .B             (B),
      .opcode        (opcode),
      .Out           (Out),
      .zero          (zero),
      .pc_in         (pc_in),
      .pc_plus1      (pc_plus1),
      .captured_data (captured_data),
      .bios_addr     (bios_addr),
      .bios_we       (bios_we),
      .bios_done     (bios_done)
   );

   task automatic test_reset();
      reset = 1'b0;
      #1;
      vectors++;
      if ({captured_data, bios_addr, bios_we, bios_done} !== 66'h0) begin
         miscompares++;
         $display("FAIL reset_async data=%h addr=%h we=%b done=%b expected all 0",
                  captured_data, bios_addr, bios_we, bios_done);
      end
      @(posedge clock);
      @(negedge clock);
      vectors++;
      if ({captured_data, bios_addr, bios_we, bios_done} !== 66'h0) begin
         miscompares++;
         $display("FAIL reset_held data=%h addr=%h we=%b done=%b expected all 0",
                  captured_data, bios_addr, bios_we, bios_done);
      end
   endtask

   task automatic test_alu();
      logic [4:0]  v_op [20];
      logic [31:0] v_a  [20];
      logic [31:0] v_b  [20];
      logic [31:0] v_out[20];
      v_op = '{5'd0, 5'd1, 5'd1, 5'd11, 5'd12, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6,
               5'd7, 5'd13, 5'd14, 5'd15, 5'd9, 5'd10, 5'd8, 5'd16, 5'd20, 5'd31};
      v_a  = '{32'd5, 32'd5, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5,
               32'd5, 32'd5, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, 32'd5, 32'd9};
      v_b  = '{32'd3, 32'd3, 32'd7, 32'd1, 32'd1, 32'd3, 32'd3, 32'd3, 32'd3, 32'd3,
               32'd3, 32'd3, 32'd3, 32'd3, 32'd4, 32'd4, 32'd31, 32'h1234, 32'd3, 32'd9};
      v_out = '{32'd8, 32'd2, 32'd0, 32'd1, 32'd0, 32'd1, 32'd7, 32'd6, 32'hFFFF_FFFA, 32'hFFFF_FFFE,
                32'hFFFF_FFF8, 32'd3, 32'd6, 32'd4, 32'h0800_0000, 32'hF800_0000, 32'h8000_0000,
                32'h1234_0000, 32'd0, 32'd0};
      for (int i = 0; i < 20; i++) begin
         opcode = v_op[i];
         A      = v_a[i];
         B      = v_b[i];
         #1;
         vectors++;
         if (Out !== v_out[i] || zero !== (v_out[i] == 32'h0)) begin
            miscompares++;
            $display("FAIL alu_op%0d A=%h B=%h got Out=%h zero=%b expected Out=%h zero=%b",
                     v_op[i], v_a[i], v_b[i], Out, zero, v_out[i], (v_out[i] == 32'h0));
         end
      end
   endtask

   task automatic test_adder();
      logic [31:0] v_pc  [3] = '{32'h0, 32'hFFFF_FFFF, 32'h0000_00FF};
      logic [31:0] v_exp [3] = '{32'h1, 32'h0, 32'h0000_0100};
      for (int i = 0; i < 3; i++) begin
         pc_in = v_pc[i];
         #1;
         vectors++;
         if (pc_plus1 !== v_exp[i]) begin
            miscompares++;
            $display("FAIL adder pc_in=%h got %h expected %h", v_pc[i], pc_plus1, v_exp[i]);
         end
      end
   endtask

   task automatic test_bios_stream();
      @(negedge clock);
      reset = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge clock);
         @(negedge clock);
         vectors++;
         if (bios_addr !== 32'(k) || captured_data !== rom_exp[k] || bios_we !== 1'b1 ||
             bios_done !== 1'b0) begin
            miscompares++;
            $display("FAIL bios_word%0d got addr=%h data=%h we=%b done=%b expected addr=%h data=%h we=1 done=0",
                     k, bios_addr, captured_data, bios_we, bios_done, 32'(k), rom_exp[k]);
         end
      end
      for (int e = 0; e < 3; e++) begin
         @(posedge clock);
         @(negedge clock);
         vectors++;
         if (bios_we !== 1'b0 || bios_done !== 1'b1 || captured_data !== 32'h0) begin
            miscompares++;
            $display("FAIL bios_done_edge%0d got we=%b done=%b data=%h expected we=0 done=1 data=0",
                     e, bios_we, bios_done, captured_data);
         end
      end
   endtask

   task automatic test_reset_midstream();
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clock);
         @(negedge clock);
      end
      vectors++;
      if (bios_addr !== 32'd2 || captured_data !== 32'h0231_2000 || bios_we !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_word2 got addr=%h data=%h we=%b expected addr=2 data=02312000 we=1",
                  bios_addr, captured_data, bios_we);
      end
      reset = 1'b0;
      #1;
      vectors++;
      if ({captured_data, bios_addr, bios_we, bios_done} !== 66'h0) begin
         miscompares++;
         $display("FAIL mid_abort data=%h addr=%h we=%b done=%b expected all 0",
                  captured_data, bios_addr, bios_we, bios_done);
      end
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      vectors++;
      if (bios_addr !== 32'd0 || captured_data !== 32'h0110_0005 || bios_we !== 1'b1 ||
          bios_done !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_restart got addr=%h data=%h we=%b done=%b expected addr=0 data=01100005 we=1 done=0",
                  bios_addr, captured_data, bios_we, bios_done);
      end
   endtask

   initial begin
      A      = 32'h0;
      B      = 32'h0;
      opcode = 5'd0;
      pc_in  = 32'h0;
      test_reset();
      test_alu();
      test_adder();
      test_bios_stream();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
